// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state type, sram_iface widths and the round-robin pick helper.
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  // Scan n requesters starting at rr_ptr with wrap-around; lowest rotation offset wins.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] rr_ptr, input int n);
    logic [7:0] g;
    logic [2:0] idx;
    g = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = 3'((int'(rr_ptr) + k) % n);
      if (k < n && req[idx]) g = 8'd1 << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner select, one-hot output.
module rr_picker
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  assign gnt_o = NUM_REQ'(rr_pick(8'(req_i), 3'(ptr_i), NUM_REQ));
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one sram_iface port among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_writemode,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_w_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           busy,
  output logic                           err,
  output logic                           io_start,
  output logic                           io_writemode,
  output logic [ADDR_W-1:0]              io_address,
  output logic [DATA_W-1:0]              io_w_data,
  input  logic [DATA_W-1:0]              io_r_data,
  input  logic                           io_done
);
  localparam int PW = $clog2(NUM_REQ);
  arb_state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, win_idx;
  logic [NUM_REQ-1:0] pick, gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, w_data_q, w_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wm_q, wm_d, start_q, start_d, busy_q, busy_d, err_q, err_d, tmo;

  rr_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (.req_i(req), .ptr_i(rr_ptr_q), .gnt_o(pick));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (pick[i]) win_idx = PW'(i);
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) cnt_q <= (n_rst || state_q == ISSUE) ? '0 : cnt_q + CW'(1);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d = owner_q;
    gnt_d = gnt_q;
    done_d = '0;
    rd_data_d = rd_data_q;
    wm_d = wm_q;
    addr_d = addr_q;
    w_data_d = w_data_q;
    start_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ISSUE;
        owner_d = win_idx;
        gnt_d = pick;
        wm_d = req_writemode[win_idx];
        addr_d = req_address[win_idx];
        w_data_d = req_w_data[win_idx];
        start_d = 1'b1;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (io_done || tmo) begin
        state_d = DONE;
        done_d = gnt_q;
        rd_data_d = io_done ? io_r_data : '0;
        err_d = !io_done;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d = '0;
        rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      rd_data_q <= '0;
      wm_q <= 1'b0;
      addr_q <= '0;
      w_data_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      rd_data_q <= rd_data_d;
      wm_q <= wm_d;
      addr_q <= addr_d;
      w_data_q <= w_data_d;
      start_q <= start_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end

  assign gnt = gnt_q;
  assign done = done_q;
  assign rd_data = rd_data_q;
  assign busy = busy_q;
  assign err = err_q;
  assign io_start = start_q;
  assign io_writemode = wm_q;
  assign io_address = addr_q;
  assign io_w_data = w_data_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_sram_arbiter;
  localparam int N = 3, AW = 16, DW = 32, TMO = 8;
`ifdef SRAM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0, n_rst = 1'b1;
  logic [N-1:0] req, req_writemode, gnt, done;
  logic [N-1:0][AW-1:0] req_address;
  logic [N-1:0][DW-1:0] req_w_data;
  logic [DW-1:0] rd_data, io_w_data, io_r_data;
  logic [AW-1:0] io_address;
  logic busy, err, io_start, io_writemode, io_done;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_writemode(req_writemode),
    .req_address(req_address), .req_w_data(req_w_data), .gnt(gnt), .done(done),
    .rd_data(rd_data), .busy(busy), .err(err), .io_start(io_start),
    .io_writemode(io_writemode), .io_address(io_address), .io_w_data(io_w_data),
    .io_r_data(io_r_data), .io_done(io_done)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: current owner, cycles since grant, and whether this is the done cycle.
  int own = -1, age = 0, ptr = 0;
  bit fin = 0, merr = 0, valid = 0, m_wm = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (n_rst) begin
      own = -1; fin = 0; ptr = 0; age = 0; merr = 0; m_wm = 0;
      m_addr = '0; m_wd = '0; m_rd = '0; valid = 1;
    end else if (fin) begin
      ptr = (own + 1) % N; own = -1; fin = 0; merr = 0;
    end else if (own < 0) begin
      own = pick(req, ptr);
      if (own >= 0) begin
        age = 0; m_wm = req_writemode[own]; m_addr = req_address[own]; m_wd = req_w_data[own];
      end
    end else if (age >= 1 && io_done) begin
      fin = 1; m_rd = io_r_data;
    end else if (TMO_EN && age == TMO) begin
      fin = 1; merr = 1; m_rd = '0;
    end else age++;
  end

  always @(negedge clk) if (valid) begin
    chk("m_busy", 64'(busy), 64'(own >= 0));
    chk("m_gnt", 64'(gnt), own >= 0 ? 64'(1) << own : 64'(0));
    chk("m_done", 64'(done), fin ? 64'(1) << own : 64'(0));
    chk("m_err", 64'(err), 64'(fin && merr));
    chk("m_io_start", 64'(io_start), 64'(own >= 0 && age == 0 && !fin));
    chk("m_rd_data", 64'(rd_data), 64'(m_rd));
    chk("m_io_writemode", 64'(io_writemode), 64'(m_wm));
    chk("m_io_address", 64'(io_address), 64'(m_addr));
    chk("m_io_w_data", 64'(io_w_data), 64'(m_wd));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start;
    int n;
    n = 0;
    while (!io_start && n < 20) begin
      tick;
      n++;
    end
    if (!io_start) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got io_start=0 expected 1 within 20 cycles at %0t", $time);
    end
  endtask

  initial begin
    req = '0; req_writemode = '0; req_address = '0; req_w_data = '0;
    io_done = 1'b0; io_r_data = '0;
    tick; tick;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_start", 64'(io_start), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd", 64'(rd_data), 0);
    n_rst = 1'b0;
    // single write, io_done three cycles after io_start
    req[0] = 1'b1; req_writemode[0] = 1'b1; req_address[0] = 16'h0001; req_w_data[0] = 32'hAAAAAAAA;
    wait_start;
    chk("wr_gnt", 64'(gnt), 64'b001);
    chk("wr_addr", 64'(io_address), 64'h0001);
    chk("wr_data", 64'(io_w_data), 64'hAAAAAAAA);
    chk("wr_wm", 64'(io_writemode), 1);
    tick;
    chk("wr_start_low", 64'(io_start), 0);
    chk("wr_addr_wait", 64'(io_address), 64'h0001);
    tick; tick;
    io_done = 1'b1;
    tick;
    io_done = 1'b0;
    chk("wr_done", 64'(done), 64'b001);
    chk("wr_gnt_done", 64'(gnt), 64'b001);
    req[0] = 1'b0;
    tick;
    chk("wr_gnt_clr", 64'(gnt), 0);
    chk("wr_idle", 64'(busy), 0);
    // single read
    req[1] = 1'b1; req_writemode[1] = 1'b0; req_address[1] = 16'h00F9;
    wait_start;
    chk("rd_gnt", 64'(gnt), 64'b010);
    chk("rd_addr", 64'(io_address), 64'h00F9);
    tick;
    io_done = 1'b1; io_r_data = 32'h12345678;
    tick;
    io_done = 1'b0;
    chk("rd_done", 64'(done), 64'b010);
    chk("rd_value", 64'(rd_data), 64'h12345678);
    req = '0;
    tick;
    // all requesters high from reset release
    n_rst = 1'b1; req = 3'b111;
    tick;
    n_rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      wait_start;
      chk("rot_gnt", 64'(gnt), 64'(1) << (t % N));
      tick;
      io_done = 1'b1;
      tick;
      io_done = 1'b0;
      chk("rot_done", 64'(done), 64'(1) << (t % N));
      if (t == 5) req = '0;
      tick;
    end
    // command change during WAIT is ignored
    req[0] = 1'b1; req_address[0] = 16'h0001;
    wait_start;
    chk("cc_gnt", 64'(gnt), 64'b001);
    tick;
    req_address[0] = 16'h0002;
    tick;
    chk("cc_addr_wait", 64'(io_address), 64'h0001);
    io_done = 1'b1;
    tick;
    io_done = 1'b0;
    chk("cc_addr_done", 64'(io_address), 64'h0001);
    chk("cc_done", 64'(done), 64'b001);
    req = '0;
    tick;
    // reset during WAIT
    req = 3'b011;
    wait_start;
    chk("rw_gnt", 64'(gnt), 64'b010);
    tick;
    n_rst = 1'b1;
    tick;
    chk("rw_busy", 64'(busy), 0);
    chk("rw_gnt_clr", 64'(gnt), 0);
    chk("rw_start", 64'(io_start), 0);
    chk("rw_done", 64'(done), 0);
    n_rst = 1'b0;
    wait_start;
    chk("rw_restart", 64'(gnt), 64'b001);
    tick;
    io_done = 1'b1;
    tick;
    io_done = 1'b0;
    chk("rw_done2", 64'(done), 64'b001);
    req = '0;
    tick;
    // no io_done: watchdog or indefinite wait
    req[2] = 1'b1;
    wait_start;
`ifdef SRAM_ARB_TIMEOUT_EN
    repeat (8) tick;
    chk("tmo_early", 64'(done), 0);
    tick;
    chk("tmo_done", 64'(done), 64'b100);
    chk("tmo_err", 64'(err), 1);
    chk("tmo_rd", 64'(rd_data), 0);
`else
    repeat (20) tick;
    chk("hang_busy", 64'(busy), 1);
    chk("hang_done", 64'(done), 0);
    io_done = 1'b1;
    tick;
    io_done = 1'b0;
    chk("hang_release", 64'(done), 64'b100);
    chk("hang_err", 64'(err), 0);
`endif
    req = '0;
    tick;
    // randomized traffic with io_done noise and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && done[i]) req[i] = 1'($urandom_range(0, 1));
        else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_writemode[i] = 1'($urandom_range(0, 1));
          req_address[i] = AW'($urandom);
          req_w_data[i] = $urandom;
        end
        if ($urandom_range(0, 15) == 0) req_address[i] = AW'($urandom);
      end
      io_done = $urandom_range(0, 2) == 0;
      io_r_data = $urandom;
      n_rst = $urandom_range(0, 199) == 0;
      tick;
    end
    n_rst = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single sram_iface port (start/writemode/i_address/i_w_data/i_r_data/io_done) between NUM_REQ requesters, e.g. AHB image loader, edge-detector pixel reader and result writer.
- Round-robin arbitration; one SRAM transaction in flight at a time.
- Latches the winner's command, strobes sram_iface, waits for io_done, then returns read data and a done pulse to the winner.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, SRAM word address width
- DATA_W, 32, SRAM data width
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with SRAM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  reset; synchronous and active-high (1 = reset), name kept per codebase convention
- req  in  NUM_REQ  per-requester request, level, held until that requester's done
- req_writemode  in  NUM_REQ  1 = write, 0 = read
- req_address  in  NUM_REQ x ADDR_W  per-requester address
- req_w_data  in  NUM_REQ x DATA_W  per-requester write data
- gnt  out  NUM_REQ  one-hot, marks the current owner from ISSUE through DONE
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- rd_data  out  DATA_W  read data, valid while done is high
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle timeout pulse, coincident with done
- io_start  out  1  to sram_iface start
- io_writemode  out  1  to sram_iface writemode
- io_address  out  ADDR_W  to sram_iface i_address
- io_w_data  out  DATA_W  to sram_iface i_w_data
- io_r_data  in  DATA_W  from sram_iface i_r_data
- io_done  in  1  from sram_iface io_done

Behaviour:
- All outputs are registered.
- Reset: state = IDLE; rr_ptr = 0; all outputs are 0.
- States and transitions:
  - IDLE: if any req is set, pick the winner, latch its writemode, address and w_data, set gnt, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: io_start = 1 for exactly one cycle, then go to WAIT.
  - WAIT: io_start = 0; hold io_* stable. When io_done is sampled high, capture io_r_data into rd_data and go to DONE.
  - DONE: done[owner] = 1 for one cycle. Set rr_ptr = (owner+1) mod NUM_REQ. Clear gnt. Go to IDLE.
- Arbitration: scan from rr_ptr upward with wrap-around; the first set req wins.
  - Simultaneous requests are resolved purely by this rotation, so no requester starves.
  - A requester is served at most once per NUM_REQ grants while others are pending.
- Latency: req rises in cycle N, so io_start is high in N+1. If io_done is sampled in cycle M, done is high in M+1. Minimum turnaround is 4 cycles with io_done one cycle after start.
- Back-to-back: a requester holding req through its done pulse is re-arbitrated in the following IDLE; with other requests pending it is served last.
- Command inputs are sampled only in IDLE. Changes during ISSUE/WAIT are ignored.
- req dropped mid-transaction: the transaction completes and done is still pulsed.
- io_done high outside WAIT: ignored.
- rd_data holds its last value after done. For a write transaction it is loaded with io_r_data anyway; that value is don't-care.
- n_rst mid-transaction: immediate return to IDLE with outputs cleared. No done is produced. The requester re-requests.

Optional Feature:
- SRAM_ARB_TIMEOUT_EN defined:
  - WAIT counts cycles from 0.
  - If the count reaches TIMEOUT_CYCLES-1 without io_done, go to DONE with rd_data = 0 and err = 1 alongside done.
  - The counter clears on entry to WAIT.
- Not defined: WAIT waits indefinitely; err is tied 0 and no counter is synthesized.

Decomposition:
- Package sram_arb_pkg:
  - typedef arb_state_t (IDLE, ISSUE, WAIT, DONE)
  - constants SRAM_ADDR_W = 16 and SRAM_DATA_W = 32 (match sram_iface)
  - function rr_pick(req, rr_ptr), returning one-hot
- Sub-module rr_picker: combinational round-robin winner select, parameterised by NUM_REQ; instantiated once in sram_arbiter.

Test Plan:
- Single write: req[0] with addr 0x0001, data 0xAAAAAAAA, writemode 1; stub io_done 3 cycles after io_start.
  → io_start one cycle; io_address = 0x0001, io_w_data = 0xAAAAAAAA stable through WAIT; done[0] in the cycle after io_done; gnt = 3'b001 from ISSUE through DONE.
- Single read: req[1] with addr 0x00F9, io_r_data = 0x12345678 at io_done.
  → done[1] = 1 with rd_data = 0x12345678.
- All three req high continuously from reset release.
  → grant order 0, 1, 2, 0, 1, 2; each done pulses exactly once per rotation.
- Command change during WAIT: req_address[0] changes 0x0001 → 0x0002.
  → io_address stays 0x0001 until DONE.
- n_rst asserted in WAIT for one cycle.
  → next cycle busy = 0, gnt = 0, io_start = 0, no done; new request after reset begins at requester 0.
- With SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, io_done never asserted.
  → done and err both pulse 8 cycles after WAIT entry, rd_data = 0; without the macro, busy stays 1 indefinitely.
